// File: rtl/ifu_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction-fetch unit.
package ifu_pkg;
  localparam int unsigned XLEN_MAX = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN_MAX-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         instr;
    logic                filled;
  } fq_entry_t;
endpackage

// File: rtl/ifu_fetchq.sv
// Instruction fetch with an in-order allocate-then-fill queue; redirects discard stale fetches.
// All channels are valid/ready: a transfer happens on a posedge where both are high, valid never waits on ready.
module ifu_fetchq
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_instr,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_snxt_pc,
  input  logic            out_ready
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] LIM = DEPTH[CW:0];

  fq_entry_t       r_q [DEPTH];
  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_alloc;
  logic [PW-1:0]   r_fill;
  logic [PW-1:0]   r_head;
  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_pend;

  logic [CW:0]     w_inflight;
  fq_entry_t       w_head;
  logic            w_req_fire;
  logic            w_out_fire;
  logic            w_rsp_drop;
  logic            w_rsp_fill;
  logic            w_rsp_owed;

  // r_pend counts allocated-but-unfilled entries; it is what a redirect turns into owed drops.
  assign w_inflight  = {1'b0, r_occ} + {1'b0, r_drop};
  assign w_head      = r_q[r_head];

  assign req_valid   = !rst && !redirect_en && (w_inflight < LIM);
  assign req_addr    = r_pc;
  assign out_valid   = !rst && !redirect_en && w_head.filled;
  assign out_pc      = rst ? '0 : w_head.pc[XLEN-1:0];
  assign out_instr   = out_valid ? w_head.instr : NOP_INSTR;
  assign out_snxt_pc = out_pc + XLEN'(4);

  assign w_req_fire  = req_valid && req_ready;
  assign w_out_fire  = out_valid && out_ready;
  assign w_rsp_drop  = rsp_valid && (r_drop != '0);
  assign w_rsp_fill  = rsp_valid && (r_drop == '0) && (r_pend != '0);
  assign w_rsp_owed  = rsp_valid && ((r_drop != '0) || (r_pend != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_alloc <= '0;
      r_fill  <= '0;
      r_head  <= '0;
      r_occ   <= '0;
      r_drop  <= '0;
      r_pend  <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (redirect_en) begin
      // A response landing this cycle pays off one of the requests being discarded.
      r_pc    <= redirect_pc;
      r_alloc <= '0;
      r_fill  <= '0;
      r_head  <= '0;
      r_occ   <= '0;
      r_pend  <= '0;
      r_drop  <= r_drop + r_pend - CW'(w_rsp_owed);
      for (int i = 0; i < DEPTH; i++) r_q[i].filled <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_q[r_alloc] <= '{pc: XLEN_MAX'(r_pc), instr: NOP_INSTR, filled: 1'b0};
        r_pc         <= r_pc + XLEN'(4);
        r_alloc      <= r_alloc + PW'(1);
      end
      if (w_rsp_fill) begin
        r_q[r_fill].instr  <= rsp_instr;
        r_q[r_fill].filled <= 1'b1;
        r_fill             <= r_fill + PW'(1);
      end
      if (w_out_fire) begin
        r_q[r_head].filled <= 1'b0;
        r_head             <= r_head + PW'(1);
      end
      if (w_rsp_drop) r_drop <= r_drop - CW'(1);
      r_occ  <= r_occ + CW'(w_req_fire) - CW'(w_out_fire);
      r_pend <= r_pend + CW'(w_req_fire) - CW'(w_rsp_fill);
    end
  end

  // A response with nothing owed is an environment bug; the logic above simply ignores it.
  a_rsp_owed: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> ((r_drop != '0) || (r_pend != '0)));
endmodule

// File: tb/tb_ifu_fetchq.sv
// Directed and randomised bench for ifu_fetchq with an in-order memory model and output scoreboard.
module tb_ifu_fetchq;
  localparam int          XLEN   = 64;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect_en, req_ready, rsp_valid, out_ready;
  logic [63:0] redirect_pc, req_addr, out_pc, out_snxt_pc;
  logic        req_valid, out_valid;
  logic [31:0] rsp_instr, out_instr;

  ifu_fetchq #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_snxt_pc(out_snxt_pc), .out_ready(out_ready)
  );

  // clock
  always #5 clk = ~clk;

  // next-cycle stimulus, applied on the falling edge
  logic        n_rst = 1'b1, n_redirect_en = 1'b0, n_req_ready = 1'b0, n_out_ready = 1'b0;
  logic [63:0] n_redirect_pc = '0;

  // memory model: accepted requests, answered in order once due
  logic        mem_hold = 1'b0;
  int          mem_dmin = 1, mem_dmax = 1;
  logic [63:0] mq_addr[$];
  int          mq_due[$];

  // scoreboard
  logic [XLEN-1:0] exp_q[$];
  int          buf_cnt = 0, m_drop = 0;
  logic [63:0] m_pc = RST_PC;

  int          cyc = 0, n_tests = 0, n_fail = 0;
  int          req_cnt = 0, out_cnt = 0, first_req_cyc = -1, first_out_cyc = -1;
  logic [63:0] first_out_pc = '1, last_out_pc = '0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick();
    logic        exp_rv, exp_ov;
    logic [63:0] e_pc;
    @(negedge clk);
    rst           = n_rst;
    redirect_en   = n_redirect_en;
    redirect_pc   = n_redirect_pc;
    req_ready     = n_req_ready;
    out_ready     = n_out_ready;
    n_redirect_en = 1'b0;
    if (!mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_instr = instr_of(mq_addr[0]);
    end else begin
      rsp_valid = 1'b0;
      rsp_instr = '0;
    end
    #1;
    exp_rv = !rst && !redirect_en && (mq_addr.size() + buf_cnt < DEPTH);
    exp_ov = !rst && !redirect_en && (buf_cnt > 0);
    check("req_valid", 64'(req_valid), 64'(exp_rv));
    check("occ_drop_bound", 64'(mq_addr.size() + buf_cnt <= DEPTH), 64'(1));
    if (req_valid) check("req_addr", req_addr, m_pc);
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    if (rst) begin
      check("rst_out_pc", out_pc, 64'(0));
      check("rst_out_snxt_pc", out_snxt_pc, 64'(4));
      check("rst_out_instr", 64'(out_instr), 64'(NOP));
    end else if (out_valid) begin
      e_pc = (exp_q.size() > 0) ? exp_q[0] : '1;
      check("out_pc", out_pc, e_pc);
      check("out_instr", 64'(out_instr), 64'(instr_of(e_pc)));
      check("out_snxt_pc", out_snxt_pc, e_pc + 64'(4));
    end else begin
      check("idle_out_instr", 64'(out_instr), 64'(NOP));
    end

    if (rst) begin
      mq_addr.delete(); mq_due.delete(); exp_q.delete();
      buf_cnt = 0; m_drop = 0; m_pc = RST_PC;
    end else if (redirect_en) begin
      if (rsp_valid) begin
        void'(mq_addr.pop_front()); void'(mq_due.pop_front());
      end
      m_drop  = mq_addr.size();
      buf_cnt = 0;
      exp_q.delete();
      m_pc    = redirect_pc;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (buf_cnt > 0) buf_cnt--;
        out_cnt++;
        if (first_out_cyc < 0) begin
          first_out_cyc = cyc;
          first_out_pc  = out_pc;
        end
        last_out_pc = out_pc;
      end
      if (rsp_valid) begin
        void'(mq_addr.pop_front()); void'(mq_due.pop_front());
        if (m_drop > 0) m_drop--;
        else buf_cnt++;
      end
      if (req_valid && req_ready) begin
        mq_addr.push_back(req_addr);
        mq_due.push_back(cyc + $urandom_range(mem_dmax, mem_dmin));
        exp_q.push_back(m_pc);
        m_pc = m_pc + 64'(4);
        req_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_instr = '0; out_ready = 1'b0;

    // reset, then streaming with a 1-cycle memory
    n_rst = 1'b1; repeat (3) tick();
    n_rst = 1'b0; n_req_ready = 1'b1; n_out_ready = 1'b1;
    first_req_cyc = -1; first_out_cyc = -1; out_cnt = 0;
    repeat (12) tick();
    check("first_out_latency", 64'(first_out_cyc - first_req_cyc), 64'(2));
    check("first_out_pc", first_out_pc, RST_PC);
    check("stream_out_count", 64'(out_cnt), 64'(10));
    check("stream_last_pc", last_out_pc, RST_PC + 64'h24);

    // decode stall fills the queue
    n_rst = 1'b1; tick(); n_rst = 1'b0;
    n_out_ready = 1'b0; req_cnt = 0;
    repeat (10) tick();
    check("stall_req_count", 64'(req_cnt), 64'(4));
    check("stall_out_pc", out_pc, RST_PC);
    check("stall_out_instr", 64'(out_instr), 64'(instr_of(RST_PC)));
    n_out_ready = 1'b1; out_cnt = 0;
    repeat (4) tick();
    check("release_out_count", 64'(out_cnt), 64'(4));
    repeat (6) tick();
    check("fetch_resumed", 64'(req_cnt > 4), 64'(1));

    // redirect with three requests outstanding
    n_rst = 1'b1; tick(); n_rst = 1'b0;
    mem_hold = 1'b1; req_cnt = 0;
    repeat (3) tick();
    n_req_ready = 1'b0; tick();
    check("outstanding_before_redirect", 64'(req_cnt), 64'(3));
    n_redirect_pc = 64'h0000_0000_8000_1000; n_redirect_en = 1'b1; tick();
    mem_hold = 1'b0; n_req_ready = 1'b1; first_out_cyc = -1; first_out_pc = '1;
    repeat (12) tick();
    check("redirect_first_pc", first_out_pc, 64'h0000_0000_8000_1000);

    // redirect coinciding with a response and a ready decode
    n_redirect_pc = 64'h0000_0000_8000_2000; n_redirect_en = 1'b1; tick();
    check("redirect_rsp_present", 64'(rsp_valid), 64'(1));
    check("redirect_no_output", 64'(out_valid), 64'(0));
    first_out_cyc = -1; first_out_pc = '1; out_cnt = 0;
    repeat (10) tick();
    check("post_redirect_first_pc", first_out_pc, 64'h0000_0000_8000_2000);
    check("post_redirect_out_count", 64'(out_cnt), 64'(8));

    // random ready and memory latency with occasional redirects
    mem_dmin = 1; mem_dmax = 3;
    for (int i = 0; i < 300; i++) begin
      n_req_ready = 1'($urandom_range(1, 0));
      n_out_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(24, 0) == 0) begin
        n_redirect_en = 1'b1;
        n_redirect_pc = 64'h0000_0000_8000_4000 + 64'($urandom_range(255, 0)) * 64'(4);
      end
      tick();
    end
    n_req_ready = 1'b0; n_out_ready = 1'b1;
    repeat (12) tick();
    check("drain_left", 64'(exp_q.size()), 64'(0));
    check("drain_out_valid", 64'(out_valid), 64'(0));

    // reset with two buffered instructions
    n_rst = 1'b1; tick(); n_rst = 1'b0;
    mem_dmin = 1; mem_dmax = 1; n_out_ready = 1'b0; n_req_ready = 1'b1;
    repeat (2) tick();
    n_req_ready = 1'b0;
    repeat (3) tick();
    check("buffered_before_rst", 64'(out_valid), 64'(1));
    n_rst = 1'b1; tick();
    n_rst = 1'b0; tick();
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    check("post_rst_out_instr", 64'(out_instr), 64'(NOP));
    check("post_rst_req_addr", req_addr, RST_PC);
    check("post_rst_req_valid", 64'(req_valid), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
